// File: rtl/adder_pkg.sv
// Shared constants and state type for the byte-serial multi-precision adder.
package adder_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [0:0] {
    IDLE,
    RUN
  } state_e;

endpackage

// File: rtl/byte_serial_adder_csa.sv
// 8-bit carry-select adder: ripple low nibble, high nibble precomputed for both carries.
module byte_serial_adder_csa
  import adder_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  localparam int unsigned HalfW = BYTE_W / 2;

  logic [HalfW:0] lo;
  logic [HalfW:0] hi0;
  logic [HalfW:0] hi1;

  assign lo  = {1'b0, a[HalfW-1:0]} + {1'b0, b[HalfW-1:0]} + {{HalfW{1'b0}}, cin};
  assign hi0 = {1'b0, a[BYTE_W-1:HalfW]} + {1'b0, b[BYTE_W-1:HalfW]};
  assign hi1 = {1'b0, a[BYTE_W-1:HalfW]} + {1'b0, b[BYTE_W-1:HalfW]} + {{HalfW{1'b0}}, 1'b1};

  // Low-nibble carry picks the precomputed high half.
  assign sum  = {(lo[HalfW] ? hi1[HalfW-1:0] : hi0[HalfW-1:0]), lo[HalfW-1:0]};
  assign cout = lo[HalfW] ? hi1[HalfW] : hi0[HalfW];

endmodule

// File: rtl/byte_serial_adder.sv
// Byte-serial multi-precision adder: LSB byte first, carry chained across beats,
// one registered result byte per accepted input byte.
module byte_serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned NUM_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_a,
  input  logic [BYTE_W-1:0] in_b,
  input  logic              in_cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_sum,
  output logic              out_last,
  output logic              out_cout,
  output logic              out_ovf
);

  localparam int unsigned CntW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NUM_BYTES - 1);

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              carry_q;

  logic              in_fire;
  logic              out_fire;
  logic              add_cin;
  logic [BYTE_W-1:0] add_sum;
  logic              add_cout;
  logic              is_last;
  logic              ovf;

  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Byte 0 always takes the external carry, so nothing leaks between operations.
  assign add_cin = (state_q == IDLE) ? in_cin : carry_q;
  assign is_last = (state_q == IDLE) ? (NUM_BYTES == 1) : (cnt_q == LastCnt);
  assign ovf     = (in_a[BYTE_W-1] == in_b[BYTE_W-1]) && (add_sum[BYTE_W-1] != in_a[BYTE_W-1]);

  byte_serial_adder_csa u_csa (
    .a    (in_a),
    .b    (in_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (in_fire) begin
      carry_q   <= add_cout;
      out_valid <= 1'b1;
      out_sum   <= add_sum;
      out_last  <= is_last;
      out_cout  <= is_last && add_cout;
      out_ovf   <= is_last && ovf;
      if (is_last) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= RUN;
        cnt_q   <= cnt_q + CntW'(1);
      end
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule
